// File: rtl/uart_tx_cfg_if.sv
// AXI4-Stream byte channel feeding uart_tx_cfg.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;

    modport master (output s_axis_tdata, output s_axis_tvalid, input s_axis_tready);
    modport slave  (input s_axis_tdata, input s_axis_tvalid, output s_axis_tready);
endinterface

// File: rtl/uart_tx_cfg.sv
// AXI4-Stream UART transmitter: input FIFO, runtime data bits / parity / stop bits.
// Define UART_TX_CTS_EN to add the cts_n clear-to-send input.
module uart_tx_cfg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_cfg_if.slave     axis,
    output logic             txd,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_level,
    input  logic [3:0]       data_bits,
    input  logic [1:0]       parity_mode,
    input  logic             stop_bits,
`ifdef UART_TX_CTS_EN
    input  logic             cts_n,
`endif
    input  logic [15:0]      prescale
);

    localparam int LW = FIFO_AW + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]      level_q;
    logic                  rdy_en_q;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] sh_q, mask, head;
    logic [3:0]            nbits_c, nbits_q, idx_q;
    logic [18:0]           period_c, period_q, cnt_q;
    logic                  par_en_q, par_bit_q, two_stop_q, stop2_q;
    logic                  txd_q, busy_q;
    logic                  push, pop, fifo_empty, cts_ok, bit_end, stop_last;

`ifdef UART_TX_CTS_EN
    assign cts_ok = ~cts_n;
`else
    assign cts_ok = 1'b1;
`endif

    always_comb begin
        nbits_c = data_bits;
        if (data_bits < 4'd5) begin
            nbits_c = 4'd5;
        end else if (32'(data_bits) > DATA_WIDTH) begin
            nbits_c = 4'(DATA_WIDTH);
        end
        mask = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            mask[i] = (i < int'(nbits_c));
        end
    end

    assign period_c   = (prescale == 16'd0) ? 19'd8 : {prescale, 3'b000};
    assign head       = mem[rd_ptr_q];
    assign fifo_empty = (level_q == '0);
    assign bit_end    = (cnt_q == period_q - 19'd1);
    assign stop_last  = ~two_stop_q | stop2_q;

    assign axis.s_axis_tready = rdy_en_q & (level_q != LW'(FIFO_DEPTH));
    assign push = axis.s_axis_tvalid & axis.s_axis_tready;
    // Pop either from idle or at the final stop-bit edge, so chained frames have no gap.
    assign pop  = ~fifo_empty & cts_ok &
                  ((state_q == StIdle) | ((state_q == StStop) & bit_end & stop_last));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= axis.s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // txd and busy are registered from the current state, so both trail the FSM by
    // one cycle and stay aligned with each other across the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            sh_q       <= '0;
            idx_q      <= '0;
            nbits_q    <= 4'd5;
            period_q   <= 19'd8;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            busy_q <= (state_q != StIdle);
            cnt_q  <= bit_end ? '0 : cnt_q + 19'd1;
            unique case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                    cnt_q <= '0;
                    if (pop) state_q <= StStart;
                end
                StStart: begin
                    txd_q <= 1'b0;
                    if (bit_end) begin
                        state_q <= StData;
                        idx_q   <= '0;
                    end
                end
                StData: begin
                    txd_q <= sh_q[0];
                    if (bit_end) begin
                        sh_q  <= sh_q >> 1;
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == nbits_q - 4'd1) begin
                            state_q <= par_en_q ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    txd_q <= par_bit_q;
                    if (bit_end) state_q <= StStop;
                end
                StStop: begin
                    txd_q <= 1'b1;
                    if (bit_end) begin
                        if (!stop_last) begin
                            stop2_q <= 1'b1;
                        end else if (pop) begin
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Frame format is captured only here and held until the next pop.
            if (pop) begin
                sh_q       <= head & mask;
                nbits_q    <= nbits_c;
                period_q   <= period_c;
                par_en_q   <= (parity_mode == 2'd1) | (parity_mode == 2'd2);
                par_bit_q  <= (^(head & mask)) ^ (parity_mode == 2'd2);
                two_stop_q <= stop_bits;
                stop2_q    <= 1'b0;
                cnt_q      <= '0;
            end
        end
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: table of single frames plus burst, reset and CTS sequences.
module tb_uart_tx_cfg;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        txd, busy;
    logic [4:0]  fifo_level;
    logic [3:0]  data_bits = 4'd8;
    logic [1:0]  parity_mode = 2'd0;
    logic        stop_bits = 1'b0;
    logic [15:0] prescale = 16'd2;
`ifdef UART_TX_CTS_EN
    logic        cts_n = 1'b0;
`endif

    uart_tx_cfg_if #(.DATA_WIDTH(DW)) s_if ();

    uart_tx_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .axis        (s_if),
        .txd         (txd),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
`ifdef UART_TX_CTS_EN
        .cts_n       (cts_n),
`endif
        .prescale    (prescale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  db;
        logic [1:0]  pm;
        logic        sb;
        logic [15:0] ps;
        int          period;
        logic [15:0] bits;   // expected line bits, index 0 = start bit
        int          len;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_q[$];
    logic saw_full = 1'b0;
    logic bad_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        s_if.s_axis_tdata  = d;
        s_if.s_axis_tvalid = 1'b1;
        while (s_if.s_axis_tready !== 1'b1 && n < 4000) begin
            if (fifo_level == 5'd16) saw_full = 1'b1;
            else bad_full = 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 4000) chk("push ready timeout", 32'(s_if.s_axis_tready), 32'd1);
        @(posedge clk);
        #1;
        s_if.s_axis_tvalid = 1'b0;
    endtask

    function automatic void add_frame(input logic [7:0] d, input int nb, input int pm,
                                      input int sb);
        logic p;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pm == 1) exp_q.push_back(p);
        else if (pm == 2) exp_q.push_back(~p);
        exp_q.push_back(1'b1);
        if (sb != 0) exp_q.push_back(1'b1);
    endfunction

    // Entered on the negedge of the first start-bit cycle; each bit must hold for P cycles.
    task automatic check_stream(input string name, input int p);
        int   b;
        int   bad;
        logic want;
        logic first_got;
        logic busy_all;
        b = 0;
        busy_all = 1'b1;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            first_got = want;
            bad = 0;
            for (int c = 0; c < p; c++) begin
                if (txd !== want && bad == 0) first_got = txd;
                if (txd !== want) bad++;
                if (busy !== 1'b1) busy_all = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("%s bit%0d txd", name, b), 32'(first_got), 32'(want));
            b++;
        end
        chk($sformatf("%s busy held", name), 32'(busy_all), 32'd1);
    endtask

    task automatic check_idle(input string name);
        chk($sformatf("%s idle txd", name), 32'(txd), 32'd1);
        chk($sformatf("%s idle busy", name), 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic txd_ok, busy_ok;
        s_if.s_axis_tvalid = 1'b0;
        s_if.s_axis_tdata  = '0;

        vecs[0] = '{8'hA5, 4'd8,  2'd0, 1'b0, 16'd2, 16, 16'h034A, 10};
        vecs[1] = '{8'hFF, 4'd7,  2'd1, 1'b1, 16'd1,  8, 16'h07FE, 11};
        vecs[2] = '{8'hFF, 4'd7,  2'd2, 1'b1, 16'd1,  8, 16'h06FE, 11};
        vecs[3] = '{8'h35, 4'd3,  2'd1, 1'b0, 16'd1,  8, 16'h00EA,  8};
        vecs[4] = '{8'h3C, 4'd15, 2'd2, 1'b0, 16'd2, 16, 16'h0678, 11};
        vecs[5] = '{8'h0F, 4'd6,  2'd3, 1'b0, 16'd3, 24, 16'h009E,  8};
        vecs[6] = '{8'h80, 4'd8,  2'd0, 1'b0, 16'd0,  8, 16'h0300, 10};
        vecs[7] = '{8'hE0, 4'd5,  2'd1, 1'b1, 16'd1,  8, 16'h0180,  9};

        // Reset state
        #12;
        chk("reset txd", 32'(txd), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset level", 32'(fifo_level), 32'd0);
        chk("reset tready", 32'(s_if.s_axis_tready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset tready", 32'(s_if.s_axis_tready), 32'd1);

        // Single frames from the table
        for (int v = 0; v < 8; v++) begin
            data_bits   = vecs[v].db;
            parity_mode = vecs[v].pm;
            stop_bits   = vecs[v].sb;
            prescale    = vecs[v].ps;
            push(vecs[v].data);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("v%0d latency", v), 32'(txd), 32'd1);
            @(negedge clk);
            for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(vecs[v].bits[i]);
            check_stream($sformatf("v%0d", v), vecs[v].period);
            check_idle($sformatf("v%0d", v));
            chk($sformatf("v%0d level", v), 32'(fifo_level), 32'd0);
        end

        // Burst of 20 bytes through a 16-deep FIFO
        data_bits = 4'd8; parity_mode = 2'd0; stop_bits = 1'b0; prescale = 16'd1;
        for (int i = 0; i < 20; i++) add_frame(8'(i * 37 + 11), 8, 0, 0);
        push(8'd11);
        fork
            begin
                for (int i = 1; i < 20; i++) push(8'(i * 37 + 11));
            end
            begin
                @(negedge clk); @(negedge clk); @(negedge clk);
                check_stream("burst", 8);
            end
        join
        chk("burst reached full", 32'(saw_full), 32'd1);
        chk("burst tready low only at full", 32'(bad_full), 32'd0);
        check_idle("burst");
        chk("burst level", 32'(fifo_level), 32'd0);

        // data_bits changed mid-frame applies to the next frame only
        push(8'h5A);
        push(8'hC3);
        add_frame(8'h5A, 8, 0, 0);
        add_frame(8'hC3, 5, 0, 0);
        fork
            begin
                @(negedge clk); @(negedge clk);
                check_stream("midcfg", 8);
            end
            begin
                repeat (30) @(negedge clk);
                data_bits = 4'd5;
            end
        join
        check_idle("midcfg");
        data_bits = 4'd8;

        // Reset during DATA with 3 bytes queued
        prescale = 16'd2;
        push(8'hAA); push(8'h55); push(8'hF0); push(8'h0F);
        repeat (20) @(negedge clk);
        chk("pre-reset level", 32'(fifo_level), 32'd3);
        chk("pre-reset txd in data bit0", 32'(txd), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort txd", 32'(txd), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort level", 32'(fifo_level), 32'd0);
        chk("abort tready", 32'(s_if.s_axis_tready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txd_ok = 1'b1;
        busy_ok = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (txd !== 1'b1) txd_ok = 1'b0;
            if (busy !== 1'b0) busy_ok = 1'b0;
        end
        chk("after abort txd quiet", 32'(txd_ok), 32'd1);
        chk("after abort busy quiet", 32'(busy_ok), 32'd0 + 32'(1'b1));
        chk("after abort tready", 32'(s_if.s_axis_tready), 32'd1);

`ifdef UART_TX_CTS_EN
        // Clear-to-send gating
        prescale = 16'd1;
        cts_n = 1'b1;
        push(8'h12);
        push(8'h34);
        txd_ok = 1'b1;
        busy_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1) txd_ok = 1'b0;
            if (busy !== 1'b0) busy_ok = 1'b0;
        end
        chk("cts held txd", 32'(txd_ok), 32'd1);
        chk("cts held busy quiet", 32'(busy_ok), 32'd1);
        chk("cts held level", 32'(fifo_level), 32'd2);
        add_frame(8'h12, 8, 0, 0);
        add_frame(8'h34, 8, 0, 0);
        cts_n = 1'b0;
        fork
            begin
                @(negedge clk); @(negedge clk);
                check_stream("cts", 8);
            end
            begin
                repeat (100) @(negedge clk);
                cts_n = 1'b1;
                push(8'h56);
            end
        join
        txd_ok = 1'b1;
        repeat (40) begin
            if (txd !== 1'b1) txd_ok = 1'b0;
            @(negedge clk);
        end
        chk("cts next frame held", 32'(txd_ok), 32'd1);
        chk("cts held busy", 32'(busy), 32'd0);
        chk("cts queued level", 32'(fifo_level), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
